// File: rtl/mandelbrot_pkg.sv
// Shared constants and state types for the Mandelbrot frame scheduler.
package mandelbrot_pkg;

    localparam int FRACTIONAL_BITS = 24;
    localparam int DATA_WIDTH      = 32;

    typedef logic signed [DATA_WIDTH-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } top_state_e;

    typedef enum logic [1:0] {
        FREE,
        ISSUE,
        BUSY,
        HOLD
    } slot_state_e;

endpackage

// File: rtl/mandelbrot_pixel_gen.sv
// Raster walker: steps col/row and the complex coordinate incrementally,
// using only adders so no multiplier is needed per pixel.
module mandelbrot_pixel_gen
    import mandelbrot_pkg::*;
#(
    parameter int DW        = DATA_WIDTH,
    parameter int DIM_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  logic [DW-1:0]        x_start_i,
    input  logic [DW-1:0]        y_start_i,
    input  logic [DW-1:0]        step_i,
    input  logic [DIM_WIDTH-1:0] width_i,
    input  logic [DIM_WIDTH-1:0] height_i,
    output logic [DIM_WIDTH-1:0] col_o,
    output logic [DIM_WIDTH-1:0] row_o,
    output logic [DW-1:0]        x_o,
    output logic [DW-1:0]        y_o,
    output logic                 last_o
);

    logic [DW-1:0]        x_start_q, x_start_d;
    logic [DW-1:0]        step_q, step_d;
    logic [DIM_WIDTH-1:0] width_q, width_d;
    logic [DIM_WIDTH-1:0] height_q, height_d;
    logic [DIM_WIDTH-1:0] col_q, col_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;
    logic [DW-1:0]        x_q, x_d;
    logic [DW-1:0]        y_q, y_d;
    logic                 end_of_row;

    assign end_of_row = (col_q == width_q - DIM_WIDTH'(1));

    always_comb begin
        x_start_d = x_start_q;
        step_d    = step_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        x_d       = x_q;
        y_d       = y_q;
        if (load_i) begin
            x_start_d = x_start_i;
            step_d    = step_i;
            width_d   = width_i;
            height_d  = height_i;
            col_d     = '0;
            row_d     = '0;
            x_d       = x_start_i;
            y_d       = y_start_i;
        end else if (advance_i) begin
            if (end_of_row) begin
                col_d = '0;
                row_d = row_q + DIM_WIDTH'(1);
                x_d   = x_start_q;
                y_d   = y_q + step_q;
            end else begin
                col_d = col_q + DIM_WIDTH'(1);
                x_d   = x_q + step_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_start_q <= '0;
            step_q    <= '0;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            x_start_q <= x_start_d;
            step_q    <= step_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = end_of_row && (row_q == height_q - DIM_WIDTH'(1));

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: dispatches one pixel per job to a core array and
// streams (col,row,iter) results out through a single registered slot.
module mandelbrot_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int INTEGER_BITS    = mandelbrot_pkg::DATA_WIDTH - mandelbrot_pkg::FRACTIONAL_BITS,
    parameter int FRACTIONAL_BITS = mandelbrot_pkg::FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int DIM_WIDTH       = 12,
    localparam int DW             = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic [DW-1:0]                       x_start_i,
    input  logic [DW-1:0]                       y_start_i,
    input  logic [DW-1:0]                       step_i,
    input  logic [DIM_WIDTH-1:0]                width_i,
    input  logic [DIM_WIDTH-1:0]                height_i,
    input  logic [MAX_ITER_WIDTH-1:0]           max_iter_i,
    output logic                                busy_o,
    output logic                                frame_done_o,
    output logic [NUM_CORES-1:0]                core_start_o,
    output logic [NUM_CORES*DW-1:0]             core_x0_o,
    output logic [NUM_CORES*DW-1:0]             core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0]           core_max_iter_o,
    input  logic [NUM_CORES*MAX_ITER_WIDTH-1:0] core_iter_i,
    input  logic [NUM_CORES-1:0]                core_done_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [DIM_WIDTH-1:0]                res_col_o,
    output logic [DIM_WIDTH-1:0]                res_row_o,
    output logic [MAX_ITER_WIDTH-1:0]           res_iter_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    top_state_e                state_q, state_d;
    slot_state_e               slot_q[NUM_CORES], slot_d[NUM_CORES];
    logic [DIM_WIDTH-1:0]      slot_col_q[NUM_CORES], slot_col_d[NUM_CORES];
    logic [DIM_WIDTH-1:0]      slot_row_q[NUM_CORES], slot_row_d[NUM_CORES];
    logic [MAX_ITER_WIDTH-1:0] slot_iter_q[NUM_CORES], slot_iter_d[NUM_CORES];
    logic [DW-1:0]             x0_q[NUM_CORES], x0_d[NUM_CORES];
    logic [DW-1:0]             y0_q[NUM_CORES], y0_d[NUM_CORES];
    logic [MAX_ITER_WIDTH-1:0] core_iter_w[NUM_CORES];
    logic [MAX_ITER_WIDTH-1:0] max_iter_q, max_iter_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic                      res_valid_q, res_valid_d;
    logic [DIM_WIDTH-1:0]      res_col_q, res_col_d;
    logic [DIM_WIDTH-1:0]      res_row_q, res_row_d;
    logic [MAX_ITER_WIDTH-1:0] res_iter_q, res_iter_d;

    logic                      pg_load, pg_advance, pg_last;
    logic [DIM_WIDTH-1:0]      pg_col, pg_row;
    logic [DW-1:0]             pg_x, pg_y;
    logic                      free_found, hold_found, all_free, load_en;
    int                        free_idx, hold_idx, cand;

    mandelbrot_pixel_gen #(
        .DW        (DW),
        .DIM_WIDTH (DIM_WIDTH)
    ) u_pixel_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (pg_load),
        .advance_i (pg_advance),
        .x_start_i (x_start_i),
        .y_start_i (y_start_i),
        .step_i    (step_i),
        .width_i   (width_i),
        .height_i  (height_i),
        .col_o     (pg_col),
        .row_o     (pg_row),
        .x_o       (pg_x),
        .y_o       (pg_y),
        .last_o    (pg_last)
    );

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core_io
        assign core_start_o[k]          = (slot_q[k] == ISSUE);
        assign core_x0_o[k*DW +: DW]    = x0_q[k];
        assign core_y0_o[k*DW +: DW]    = y0_q[k];
        assign core_iter_w[k]           = core_iter_i[k*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        slot_col_d   = slot_col_q;
        slot_row_d   = slot_row_q;
        slot_iter_d  = slot_iter_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        max_iter_d   = max_iter_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_col_d    = res_col_q;
        res_row_d    = res_row_q;
        res_iter_d   = res_iter_q;
        pg_load      = 1'b0;
        pg_advance   = 1'b0;
        free_found   = 1'b0;
        free_idx     = 0;
        hold_found   = 1'b0;
        hold_idx     = 0;
        all_free     = 1'b1;
        cand         = 0;
        load_en      = !res_valid_q || res_ready_i;

        for (int k = 0; k < NUM_CORES; k++) begin
            if (slot_q[k] != FREE) all_free = 1'b0;
            if (!free_found && slot_q[k] == FREE) begin
                free_found = 1'b1;
                free_idx   = k;
            end
        end

        // Round-robin search starts one past the most recent grant.
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = int'(last_grant_q) + 1 + i;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            if (!hold_found && slot_q[cand] == HOLD) begin
                hold_found = 1'b1;
                hold_idx   = cand;
            end
        end

        // During ISSUE the core still presents the previous job's done level.
        for (int k = 0; k < NUM_CORES; k++) begin
            case (slot_q[k])
                ISSUE: slot_d[k] = BUSY;
                BUSY: begin
                    if (core_done_i[k]) begin
                        slot_d[k]      = HOLD;
                        slot_iter_d[k] = core_iter_w[k];
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pg_load    = 1'b1;
                    max_iter_d = max_iter_i;
                    state_d    = (width_i == '0 || height_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (free_found) begin
                    pg_advance           = 1'b1;
                    slot_d[free_idx]     = ISSUE;
                    slot_col_d[free_idx] = pg_col;
                    slot_row_d[free_idx] = pg_row;
                    x0_d[free_idx]       = pg_x;
                    y0_d[free_idx]       = pg_y;
                    if (pg_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (all_free && !res_valid_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            res_valid_d = hold_found;
            if (hold_found) begin
                res_col_d        = slot_col_q[hold_idx];
                res_row_d        = slot_row_q[hold_idx];
                res_iter_d       = slot_iter_q[hold_idx];
                slot_d[hold_idx] = FREE;
                last_grant_d     = IDX_W'(hold_idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            max_iter_q   <= '0;
            last_grant_q <= '0;
            res_valid_q  <= 1'b0;
            res_col_q    <= '0;
            res_row_q    <= '0;
            res_iter_q   <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                slot_q[k]      <= FREE;
                slot_col_q[k]  <= '0;
                slot_row_q[k]  <= '0;
                slot_iter_q[k] <= '0;
                x0_q[k]        <= '0;
                y0_q[k]        <= '0;
            end
        end else begin
            state_q      <= state_d;
            max_iter_q   <= max_iter_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_col_q    <= res_col_d;
            res_row_q    <= res_row_d;
            res_iter_q   <= res_iter_d;
            slot_q       <= slot_d;
            slot_col_q   <= slot_col_d;
            slot_row_q   <= slot_row_d;
            slot_iter_q  <= slot_iter_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign frame_done_o    = (state_q == DONE);
    assign core_max_iter_o = max_iter_q;
    assign res_valid_o     = res_valid_q;
    assign res_col_o       = res_col_q;
    assign res_row_o       = res_row_q;
    assign res_iter_o      = res_iter_q;

endmodule
